// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Queues ALU requests in a small in-order FIFO and runs them one at a time
// through an external ALU. Each legal request goes IDLE -> ISSUE -> WAIT ->
// RESP. An illegal opcode (12..15) goes straight from IDLE to RESP with an
// error response, and the ALU never sees it. The result of the last legal
// operation can be fed back as operand A (accumulate mode).
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high. The producer holds valid (and its payload) until that edge.
// The consumer may change ready freely. rsp_valid and its payload stay stable
// until they are accepted.
//
// Ports
//   CLK, reset              clock; synchronous active-high reset
//   req_valid/req_ready     request handshake (ready = FIFO not full)
//   req_op, req_a, req_b    opcode and operands
//   req_acc                 1 = use the last captured result as operand A
//   alu_cmd, alu_a, alu_b   issued command {acc, op} and operands
//   alu_noOp                1 = ALU idle (low only in the ISSUE cycle)
//   alu_result/overflow     ALU outputs, captured ALU_LAT cycles after issue
//   rsp_valid/rsp_ready     response handshake
//   rsp_data, rsp_ovf       captured result and overflow flag
//   rsp_err                 illegal-opcode flag
//   busy                    FIFO non-empty or sequencer not idle
//   dbg_state               current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int N       = 16,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [3:0]     req_op,
    input  logic [N-1:0]   req_a,
    input  logic [N-1:0]   req_b,
    input  logic           req_acc,
    output logic [4:0]     alu_cmd,
    output logic           alu_noOp,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    input  logic [2*N-1:0] alu_result,
    input  logic           alu_overflow,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*N-1:0] rsp_data,
    output logic           rsp_ovf,
    output logic           rsp_err,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(ALU_LAT + 1);
    localparam int ENT_W = 5 + 2 * N;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state, state_next;

    // -----------------------------------------------------------------------
    // Request FIFO
    // -----------------------------------------------------------------------
    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             fifo_push, fifo_pop;

    assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign req_ready  = ~fifo_full;
    assign fifo_push  = req_valid & ~fifo_full;

    // Storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge CLK) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= {req_acc, req_op, req_a, req_b};
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head-of-queue fields
    logic [ENT_W-1:0] head;
    logic             head_acc;
    logic [3:0]       head_op;
    logic [N-1:0]     head_a, head_b;
    logic             head_illegal;

    assign head         = fifo_mem[rd_ptr];
    assign head_acc     = head[ENT_W-1];
    assign head_op      = head[ENT_W-2 -: 4];
    assign head_a       = head[2*N-1:N];
    assign head_b       = head[N-1:0];
    assign head_illegal = head_op[3] & head_op[2];   // opcodes 12..15

    // -----------------------------------------------------------------------
    // Sequencer FSM
    // -----------------------------------------------------------------------
    logic             issue_load, err_load, cnt_load, cnt_dec, capture;
    logic [LAT_W-1:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        issue_load = 1'b0;
        err_load   = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        alu_noOp   = 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_illegal) begin
                        err_load   = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        issue_load = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                alu_noOp   = 1'b0;
                cnt_load   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // The counter reaches 1 in the last WAIT cycle. That is when
                // the ALU output is valid and gets captured.
                if (wait_cnt == LAT_W'(1)) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Issue / response datapath
    // -----------------------------------------------------------------------
    logic [4:0]     cmd_r;
    logic [N-1:0]   a_r, b_r;
    logic [N-1:0]   last_result;
    logic [2*N-1:0] data_r;
    logic           ovf_r, err_r;

    always_ff @(posedge CLK) begin
        if (reset) begin
            cmd_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            wait_cnt    <= '0;
            last_result <= '0;
            data_r      <= '0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            // last_result changes only when a result is captured. No capture
            // can happen between this pop and ISSUE, so sampling it here gives
            // the same value ISSUE would see.
            if (issue_load) begin
                cmd_r <= {head_acc, head_op};
                a_r   <= head_acc ? last_result : head_a;
                b_r   <= head_b;
            end
            if (cnt_load) wait_cnt <= LAT_W'(ALU_LAT);
            else if (cnt_dec) wait_cnt <= wait_cnt - LAT_W'(1);
            if (capture) begin
                data_r      <= alu_result;
                ovf_r       <= alu_overflow;
                err_r       <= 1'b0;
                last_result <= alu_result[N-1:0];
            end else if (err_load) begin
                data_r <= '0;
                ovf_r  <= 1'b0;
                err_r  <= 1'b1;
            end
        end
    end

    assign alu_cmd   = cmd_r;
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = data_r;
    assign rsp_ovf   = ovf_r;
    assign rsp_err   = err_r;
    assign busy      = ~fifo_empty | (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for alu_cmd_sequencer: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int N       = 16;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic           CLK;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [3:0]     req_op;
    logic [N-1:0]   req_a, req_b;
    logic           req_acc;
    logic [4:0]     alu_cmd;
    logic           alu_noOp;
    logic [N-1:0]   alu_a, alu_b;
    logic [2*N-1:0] alu_result;
    logic           alu_overflow;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*N-1:0] rsp_data;
    logic           rsp_ovf, rsp_err;
    logic           busy;
    logic [1:0]     dbg_state;

    alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
        .alu_cmd(alu_cmd), .alu_noOp(alu_noOp), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int issue_seen = 0;
    int rsp_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- ALU behaviour (external ALU and reference) ----------------
    function automatic logic [2*N:0] alu_model(input logic [3:0] op, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        logic [2*N-1:0] r;
        logic           o;
        logic [2*N-1:0] za, zb;
        za = {{N{1'b0}}, a};
        zb = {{N{1'b0}}, b};
        r = '0;
        o = 1'b0;
        case (op)
            4'd0:  begin r = za + zb; o = r[N]; end
            4'd1:  begin r = {{N{1'b0}}, a - b}; o = (a < b); end
            4'd2:  r = za * zb;
            4'd3:  begin
                       if (b == '0) o = 1'b1;
                       else r = {a % b, a / b};
                   end
            4'd4:  r = {{N{1'b0}}, a << b[3:0]};
            4'd5:  r = {{N{1'b0}}, a >> b[3:0]};
            4'd6:  r = {{N{1'b0}}, a & b};
            4'd7:  r = {{N{1'b0}}, a | b};
            4'd8:  r = {{N{1'b0}}, a ^ b};
            4'd9:  r = {{N{1'b0}}, ~a};
            4'd10: r = {{N{1'b0}}, ~(a & b)};
            4'd11: r = {{N{1'b0}}, ~(a | b)};
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    // The external ALU presents its result continuously from the held command.
    always_comb begin
        {alu_overflow, alu_result} = alu_model(alu_cmd[3:0], alu_a, alu_b);
    end

    // ---------------- scoreboard / reference model ----------------
    logic [2*N+1:0] exp_q[$];   // {data, ovf, err}, in request order
    logic [4+2*N:0] iss_q[$];   // {cmd, a, b} expected on the ALU for legal requests
    logic [N-1:0]   model_last;
    logic [2*N+1:0] mon_rsp;
    logic [4+2*N:0] mon_iss;

    task automatic model_accept(input logic [3:0] op, input logic [N-1:0] a,
                                input logic [N-1:0] b, input logic acc);
        logic [N-1:0] a_eff;
        logic [2*N:0] r;
        if (op >= 4'd12) begin
            exp_q.push_back({{(2*N){1'b0}}, 1'b0, 1'b1});
        end else begin
            a_eff = acc ? model_last : a;
            r = alu_model(op, a_eff, b);
            iss_q.push_back({acc, op, a_eff, b});
            exp_q.push_back({r[2*N-1:0], r[2*N], 1'b0});
            model_last = r[N-1:0];
        end
    endtask

    always @(negedge CLK) begin
        if (reset) begin
            exp_q.delete();
            iss_q.delete();
            model_last = '0;
        end else begin
            if (!alu_noOp) begin
                issue_seen++;
                if (iss_q.size() == 0) fail_now("unexpected_issue");
                else begin
                    mon_iss = iss_q.pop_front();
                    check("issue_cmd_a_b", {alu_cmd, alu_a, alu_b}, mon_iss);
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) fail_now("spurious_rsp");
                else if (rsp_ready) begin
                    rsp_seen++;
                    mon_rsp = exp_q.pop_front();
                    check("rsp_data_ovf_err", {rsp_data, rsp_ovf, rsp_err}, mon_rsp);
                end
            end
            if (req_valid && req_ready) model_accept(req_op, req_a, req_b, req_acc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic acc);
        bit done;
        done = 1'b0;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_acc = acc;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        if (!done) fail_now("send_timeout");
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) fail_now("idle_timeout");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, req_ready, 1'b1);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_data"},  rsp_data, '0);
        check({tag, "_rsp_ovf"},   rsp_ovf, 1'b0);
        check({tag, "_rsp_err"},   rsp_err, 1'b0);
        check({tag, "_alu_noOp"},  alu_noOp, 1'b1);
        check({tag, "_alu_cmd"},   alu_cmd, 5'd0);
        check({tag, "_alu_a"},     alu_a, '0);
        check({tag, "_alu_b"},     alu_b, '0);
        check({tag, "_busy"},      busy, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]     op;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           acc;
        logic [2*N-1:0] data;
        logic           ovf;
        logic           err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int lat;
        int iss0;
        int rsp0;

        vecs[0]  = '{4'd0,  16'h0003, 16'h0005, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1]  = '{4'd0,  16'hFFFF, 16'h0001, 1'b0, 32'h0001_0000, 1'b1, 1'b0};
        vecs[2]  = '{4'd0,  16'h1234, 16'h0002, 1'b1, 32'h0000_0002, 1'b0, 1'b0};
        vecs[3]  = '{4'd1,  16'h000A, 16'h0003, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
        vecs[4]  = '{4'd1,  16'h0003, 16'h0005, 1'b0, 32'h0000_FFFE, 1'b1, 1'b0};
        vecs[5]  = '{4'd2,  16'h0100, 16'h0100, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[6]  = '{4'd3,  16'd100,  16'd7,    1'b0, 32'h0002_000E, 1'b0, 1'b0};
        vecs[7]  = '{4'd6,  16'hF0F0, 16'hFF00, 1'b0, 32'h0000_F000, 1'b0, 1'b0};
        vecs[8]  = '{4'd8,  16'hFFFF, 16'h00FF, 1'b0, 32'h0000_FF00, 1'b0, 1'b0};
        vecs[9]  = '{4'd9,  16'h00FF, 16'h0000, 1'b0, 32'h0000_FF00, 1'b0, 1'b0};
        vecs[10] = '{4'd13, 16'h0005, 16'h0005, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[11] = '{4'd0,  16'h7777, 16'h0001, 1'b1, 32'h0000_FF01, 1'b0, 1'b0};
        vecs[12] = '{4'd4,  16'h0001, 16'h0004, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
        vecs[13] = '{4'd11, 16'h0F0F, 16'hF000, 1'b0, 32'h0000_00F0, 1'b0, 1'b0};

        // ---------------- reset ----------------
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        req_acc = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // ---------------- table-driven single operations ----------------
        foreach (vecs[k]) begin
            wait_idle();
            iss0 = issue_seen;
            send(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].acc);
            lat = 1;
            while (!rsp_valid && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", k), lat, (vecs[k].err ? 2 : ALU_LAT + 3));
            check($sformatf("vec%0d_rsp_data", k), rsp_data, vecs[k].data);
            check($sformatf("vec%0d_rsp_ovf", k), rsp_ovf, vecs[k].ovf);
            check($sformatf("vec%0d_rsp_err", k), rsp_err, vecs[k].err);
            tick();
            check($sformatf("vec%0d_rsp_drop", k), rsp_valid, 1'b0);
            check($sformatf("vec%0d_issue_cycles", k), issue_seen - iss0, (vecs[k].err ? 0 : 1));
        end

        // ---------------- fill FIFO with rsp_ready low, hold RESP ----------------
        wait_idle();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom), 1'b0);
        end
        check("full_req_ready", req_ready, 1'b0);
        // Offer a sixth request while full; it must not be taken.
        req_valid = 1'b1;
        req_op = 4'd0;
        req_a = 16'h1111;
        req_b = 16'h2222;
        req_acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_rsp_valid", rsp_valid, 1'b1);
            if (exp_q.size() != 0) check("hold_rsp_data", {rsp_data, rsp_ovf, rsp_err}, exp_q[0]);
            else fail_now("hold_model_empty");
            check("hold_no_issue", alu_noOp, 1'b1);
            check("hold_req_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        rsp0 = rsp_seen;
        rsp_ready = 1'b1;
        wait_idle();
        tick();
        check("burst_rsp_count", rsp_seen - rsp0, 5);
        check("burst_model_empty", exp_q.size(), 0);

        // ---------------- reset during WAIT with two queued ----------------
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            send(4'd0, 16'($urandom), 16'($urandom), 1'b0);
        end
        check("midop_state_wait", dbg_state, 2'd2);
        check("midop_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        check_reset_values("midop_reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("after_reset_no_rsp", rsp_valid, 1'b0);
            check("after_reset_no_issue", alu_noOp, 1'b1);
        end

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 1500; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_op = 4'($urandom_range(0, 15));
            req_a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            req_b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            req_acc = ($urandom_range(0, 3) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        tick();
        check("drain_rsp_empty", exp_q.size(), 0);
        check("drain_issue_empty", iss_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
